ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the FPGA to an attached keyboard using the PS/2 host-request protocol. It runs on the system clock, oversamples the device-generated PS/2 clock, and drives both open-collector lines through pull-low enables. It is the counterpart of the existing PS/2 keyboard receiver and shares the same two physical lines with it.

---
 rtl/ps2_host_tx.sv | 173 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// clocks out start/data/parity/stop on device clock edges and checks the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Send,
    input  logic [7:0] TxData,
    output logic       Ready,
    output logic       Done,
    output logic       Error,
    input  logic       PS2_Clock_In,
    input  logic       PS2_Data_In,
    output logic       PS2_Clock_Drive,
    output logic       PS2_Data_Drive
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_XFER, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic              clk_s1_q, clk_s2_q, clk_prev_q;
    logic              dat_s1_q, dat_s2_q;
    logic [INH_W-1:0]  inh_q, inh_d;
    logic [TO_W-1:0]   to_q, to_d, to_inc;
    logic [3:0]        idx_q, idx_d;
    logic              ddrv_q, ddrv_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        byte_q;
    logic              par_q;
    logic              accept;
    logic              fe;

    // Synchronisers idle high so a line that is already high never looks like an edge.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= PS2_Clock_In;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= PS2_Data_In;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fe = clk_prev_q & ~clk_s2_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            inh_q   <= '0;
            to_q    <= '0;
            idx_q   <= '0;
            ddrv_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inh_q   <= inh_d;
            to_q    <= to_d;
            idx_q   <= idx_d;
            ddrv_q  <= ddrv_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (accept) begin
            byte_q <= TxData;
            par_q  <= ~^TxData;
        end
    end

    assign to_inc = (to_q == TO_MAX) ? to_q : to_q + 1'b1;

    always_comb begin
        state_d = state_q;
        inh_d   = inh_q;
        to_d    = to_q;
        idx_d   = idx_q;
        ddrv_d  = ddrv_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ddrv_d = 1'b0;
                if (Send) begin
                    accept  = 1'b1;
                    inh_d   = '0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_q == INH_LAST) begin
                    ddrv_d  = 1'b1;
                    state_d = S_REQ;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            S_REQ: begin
                idx_d   = '0;
                to_d    = '0;
                state_d = S_XFER;
            end
            S_XFER: begin
                to_d = to_inc;
                if (to_q >= TO_LAST) begin
                    err_d   = 1'b1;
                    ddrv_d  = 1'b0;
                    state_d = S_WAIT_IDLE;
                end else if (fe) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q < 4'd8) begin
                        ddrv_d = ~byte_q[idx_q[2:0]];
                    end else if (idx_q == 4'd8) begin
                        ddrv_d = ~par_q;
                    end else begin
                        ddrv_d  = 1'b0;
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                to_d   = to_inc;
                ddrv_d = 1'b0;
                // The ACK edge is checked first so it wins over a coincident timeout.
                if (fe) begin
                    done_d  = ~dat_s2_q;
                    err_d   = dat_s2_q;
                    state_d = S_WAIT_IDLE;
                end else if (to_q >= TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                ddrv_d = 1'b0;
                if (clk_s2_q && dat_s2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                ddrv_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign Ready           = (state_q == S_IDLE);
    assign Done            = done_q;
    assign Error           = err_q;
    assign PS2_Clock_Drive = (state_q == S_INHIBIT) || (state_q == S_REQ);
    assign PS2_Data_Drive  = ddrv_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 keyboard model.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send = 1'b0;
    logic [7:0] txd = 8'h00;
    logic       ready, done, error, cdrv, ddrv;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk, ps2_dat;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    assign ps2_clk = ~(cdrv | dev_clk_low);
    assign ps2_dat = ~(ddrv | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(50), .TIMEOUT_CYCLES(2000)) dut (
        .Clock(clk), .Reset_n(rst_n), .Send(send), .TxData(txd),
        .Ready(ready), .Done(done), .Error(error),
        .PS2_Clock_In(ps2_clk), .PS2_Data_In(ps2_dat),
        .PS2_Clock_Drive(cdrv), .PS2_Data_Drive(ddrv)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)          done_cnt <= done_cnt + 1;
        if (error)         err_cnt  <= err_cnt + 1;
        if (done && error) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = ready;
    endtask

    // Device samples each bit mid-high, then clocks 10 low / 10 high (period 20).
    task automatic run_frame(input logic [7:0] b, input int npulses, input bit ack,
                             output logic [10:0] frame, output int hi_cnt);
        frame  = '0;
        hi_cnt = 0;
        @(negedge clk);
        txd  = b;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        txd  = ~b;
        chk("accept_ready_low", ready, 0);
        chk("accept_clkdrv_high", cdrv, 1);
        while (cdrv && hi_cnt < 200) begin
            hi_cnt++;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        for (int k = 0; k < npulses; k++) begin
            repeat (5) @(negedge clk);
            frame[k] = ps2_dat;
            if (k == 10 && ack) dev_dat_low = 1'b1;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        if (npulses == 11) begin
            repeat (5) @(negedge clk);
            dev_dat_low = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [10:0] fr;
        int          hi, t, d0, e0;
        bit          ok;

        // Reset held with Send asserted, then released with Send low.
        send = 1'b1;
        txd  = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_clkdrv", cdrv, 0);
        chk("rst_datdrv", ddrv, 0);
        send  = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", ready, 1);
        chk("post_rst_clkdrv", cdrv, 0);
        chk("post_rst_datdrv", ddrv, 0);

        // 0xED with ACK: parity 1.
        d0 = done_cnt; e0 = err_cnt;
        run_frame(8'hED, 11, 1'b1, fr, hi);
        chk("ed_inhibit_len", hi, 51);
        chk("ed_frame", {21'd0, fr}, 32'h7DA);
        wait_ready(ok);
        chk("ed_ready", ok, 1);
        chk("ed_done", done_cnt - d0, 1);
        chk("ed_error", err_cnt - e0, 0);

        // 0x00 without ACK: parity 1, Error expected.
        d0 = done_cnt; e0 = err_cnt;
        run_frame(8'h00, 11, 1'b0, fr, hi);
        chk("nack_frame", {21'd0, fr}, 32'h600);
        wait_ready(ok);
        chk("nack_ready", ok, 1);
        chk("nack_done", done_cnt - d0, 0);
        chk("nack_error", err_cnt - e0, 1);

        // Device never clocks: Error 2000 cycles after the request is released.
        d0 = done_cnt; e0 = err_cnt;
        @(negedge clk);
        txd  = 8'h12;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        t = 0;
        while (cdrv && t < 200) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (!error && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("to_latency", t, 2000);
        chk("to_clkdrv", cdrv, 0);
        chk("to_datdrv", ddrv, 0);
        wait_ready(ok);
        chk("to_ready", ok, 1);
        chk("to_error", err_cnt - e0, 1);
        chk("to_done", done_cnt - d0, 0);

        // 0x55 with a second Send (0xAA) mid-frame that must be ignored.
        d0 = done_cnt; e0 = err_cnt;
        fork
            run_frame(8'h55, 11, 1'b1, fr, hi);
            begin
                repeat (100) @(negedge clk);
                chk("busy_ready", ready, 0);
                txd  = 8'hAA;
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
        join
        chk("x55_frame", {21'd0, fr}, 32'h6AA);
        wait_ready(ok);
        chk("x55_ready", ok, 1);
        chk("x55_done", done_cnt - d0, 1);
        chk("x55_error", err_cnt - e0, 0);

        // Reset during bit 4 of 0x00, then a clean 0xF4 (parity 0).
        d0 = done_cnt; e0 = err_cnt;
        run_frame(8'h00, 4, 1'b0, fr, hi);
        chk("abort_pre_datdrv", ddrv, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_clkdrv", cdrv, 0);
        chk("abort_datdrv", ddrv, 0);
        chk("abort_ready", ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_done", done_cnt - d0, 0);
        chk("abort_error", err_cnt - e0, 0);
        run_frame(8'hF4, 11, 1'b1, fr, hi);
        chk("f4_inhibit_len", hi, 51);
        chk("f4_frame", {21'd0, fr}, 32'h5E8);
        wait_ready(ok);
        chk("f4_ready", ok, 1);
        chk("f4_done", done_cnt - d0, 1);
        chk("f4_error", err_cnt - e0, 0);

        chk("done_error_overlap", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
